// File: rtl/rv32_pkg.sv
// Shared RV32I instruction-format definitions used by decode and encode.
package rv32_pkg;

    typedef enum logic [2:0] {
        TYPE_R,
        TYPE_I,
        TYPE_S,
        TYPE_B,
        TYPE_U,
        TYPE_J,
        TYPE_ERROR
    } inst_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Width of one buffered encoder beat: {error, word}.
    localparam int unsigned ENC_BEAT_WIDTH = 33;

    // Opcode-to-format table shared with decode.
    function automatic inst_type_e classify(input logic [6:0] opcode);
        inst_type_e t;
        case (opcode)
            OPC_OP:                                       t = TYPE_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:   t = TYPE_I;
            OPC_STORE:                                    t = TYPE_S;
            OPC_BRANCH:                                   t = TYPE_B;
            OPC_LUI, OPC_AUIPC:                           t = TYPE_U;
            OPC_JAL:                                      t = TYPE_J;
            default:                                      t = TYPE_ERROR;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/encode_fifo.sv
// Two-entry in-order buffer; head entry is always presented on head_data.
module encode_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = clk_en & push & ~full;
    assign do_pop  = clk_en & pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Storage, 1-bit wrapping pointers and occupancy; reset wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/encode.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word,
// flags unencodable beats, and buffers results in a 2-entry FIFO.
module encode
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [6:0]  i_opcode,
    input  logic [7:0]  i_funct7,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_imm,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_instruction,
    output logic        o_error,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_err_count
);

    inst_type_e                inst_type;
    logic [31:0]               word;
    logic                      enc_err;
    logic [ENC_BEAT_WIDTH-1:0] beat;
    logic [ENC_BEAT_WIDTH-1:0] head;
    logic                      full;
    logic                      empty;
    logic                      accept;
    logic                      unused_funct7_msb;

    assign unused_funct7_msb = i_funct7[7];

    // Format packing and immediate range checks.
    always_comb begin
        inst_type = classify(i_opcode);
        word      = '0;
        enc_err   = 1'b0;
        case (inst_type)
            TYPE_R: begin
                word = {i_funct7[6:0], i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            TYPE_I: begin
                word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                enc_err = (i_imm[31:11] != {21{i_imm[11]}});
            end
            TYPE_S: begin
                word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                enc_err = (i_imm[31:11] != {21{i_imm[11]}});
            end
            TYPE_B: begin
                word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                enc_err = (i_imm[31:12] != {20{i_imm[12]}}) | i_imm[0];
            end
            TYPE_U: begin
                word    = {i_imm[31:12], i_rd, i_opcode};
                enc_err = (i_imm[11:0] != 12'h000);
            end
            TYPE_J: begin
                word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                enc_err = (i_imm[31:20] != {12{i_imm[20]}}) | i_imm[0];
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        beat = enc_err ? {1'b1, 32'h0} : {1'b0, word};
    end

    assign accept = clk_en & i_valid & ~full;

    encode_fifo #(
        .WIDTH(ENC_BEAT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .push      (i_valid),
        .push_data (beat),
        .pop       (i_ready),
        .head_data (head),
        .full      (full),
        .empty     (empty)
    );

    assign o_ready       = ~full;
    assign o_valid       = ~empty;
    assign o_error       = head[32];
    assign o_instruction = head[31:0];

    // Saturating count of error beats accepted at the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_count <= '0;
        end else if (accept && beat[32] && (o_err_count != 8'hFF)) begin
            o_err_count <= o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_encode.sv
// Self-checking bench for encode: behavioural queue model plus directed
// literal checks and a random encode/decode round trip.
module tb_encode;

    typedef struct {
        logic [6:0]  op;
        logic [7:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } fields_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic [6:0]  i_opcode = '0;
    logic [7:0]  i_funct7 = '0;
    logic [2:0]  i_funct3 = '0;
    logic [4:0]  i_rs1 = '0;
    logic [4:0]  i_rs2 = '0;
    logic [4:0]  i_rd = '0;
    logic [31:0] i_imm = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] o_instruction;
    logic        o_error;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_err_count;

    int tests = 0;
    int fails = 0;

    encode dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .i_opcode      (i_opcode),
        .i_funct7      (i_funct7),
        .i_funct3      (i_funct3),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_rd          (i_rd),
        .i_imm         (i_imm),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_instruction (o_instruction),
        .o_error       (o_error),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_err_count   (o_err_count)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Encoding from the ISA rules: range-check the immediate as a signed
    // number, then place bit groups with shifts and masks.
    function automatic logic [32:0] ref_encode(input fields_t f);
        logic signed [31:0] s;
        logic [31:0] w;
        logic [31:0] base;
        bit ok;
        s = f.imm;
        base = ({27'd0, f.rd} << 7) | ({29'd0, f.f3} << 12) | ({27'd0, f.rs1} << 15)
             | ({27'd0, f.rs2} << 20) | {25'd0, f.op};
        w = 32'h0;
        ok = 1'b1;
        case (f.op)
            7'h33: w = base | ({25'd0, f.f7[6:0]} << 25);
            7'h13, 7'h03, 7'h67, 7'h73: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (base & 32'h000F_FFFF & ~(32'h1F << 20)) | ((f.imm & 32'hFFF) << 20);
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (base & ~(32'h1F << 7)) | (((f.imm >> 5) & 32'h7F) << 25) | ((f.imm & 32'h1F) << 7);
            end
            7'h63: begin
                ok = (s >= -4096) && (s <= 4095) && (f.imm % 2 == 0);
                w  = (base & ~(32'h1F << 7)) | (((f.imm >> 12) & 1) << 31) | (((f.imm >> 5) & 32'h3F) << 25)
                   | (((f.imm >> 1) & 32'hF) << 8) | (((f.imm >> 11) & 1) << 7);
            end
            7'h37, 7'h17: begin
                ok = (f.imm % 4096 == 0);
                w  = (f.imm & 32'hFFFF_F000) | ({27'd0, f.rd} << 7) | {25'd0, f.op};
            end
            7'h6F: begin
                ok = (s >= -(1 << 20)) && (s <= (1 << 20) - 1) && (f.imm % 2 == 0);
                w  = (((f.imm >> 20) & 1) << 31) | (((f.imm >> 1) & 32'h3FF) << 21)
                   | (((f.imm >> 11) & 1) << 20) | (((f.imm >> 12) & 32'hFF) << 12)
                   | ({27'd0, f.rd} << 7) | {25'd0, f.op};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0};
    endfunction

    logic [32:0] exp_q[$];
    fields_t     org_q[$];
    int          m_err = 0;
    bit          armed = 0;
    bit          last_push = 0;
    bit          rt_mode = 0;
    int          rt_in = 0;
    int          rt_out = 0;

    // Model update on each rising edge from the bench-driven inputs.
    always @(posedge clk) begin
        bit do_pop, do_push;
        logic [32:0] r;
        fields_t f;
        last_push = 0;
        if (rst) begin
            exp_q.delete();
            org_q.delete();
            m_err = 0;
            armed = 1;
        end else if (clk_en) begin
            do_pop  = (exp_q.size() != 0) && i_ready;
            do_push = i_valid && (exp_q.size() < 2);
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(org_q.pop_front());
                if (rt_mode) rt_out++;
            end
            if (do_push) begin
                f = '{i_opcode, i_funct7, i_funct3, i_rs1, i_rs2, i_rd, i_imm};
                r = ref_encode(f);
                exp_q.push_back(r);
                org_q.push_back(f);
                if (r[32] && m_err < 255) m_err++;
                if (rt_mode) rt_in++;
                last_push = 1;
            end
        end
    end

    // Independent field extraction used to close the round trip.
    task automatic rt_check(input fields_t o, input logic [31:0] w);
        logic [31:0] imm;
        chk("rt_opcode", {25'd0, w[6:0]}, {25'd0, o.op});
        case (o.op)
            7'h33: begin
                chk("rt_rd",  {27'd0, w[11:7]},  {27'd0, o.rd});
                chk("rt_f3",  {29'd0, w[14:12]}, {29'd0, o.f3});
                chk("rt_rs1", {27'd0, w[19:15]}, {27'd0, o.rs1});
                chk("rt_rs2", {27'd0, w[24:20]}, {27'd0, o.rs2});
                chk("rt_f7",  {25'd0, w[31:25]}, {25'd0, o.f7[6:0]});
            end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                imm = {{20{w[31]}}, w[31:20]};
                chk("rt_rd",  {27'd0, w[11:7]},  {27'd0, o.rd});
                chk("rt_f3",  {29'd0, w[14:12]}, {29'd0, o.f3});
                chk("rt_rs1", {27'd0, w[19:15]}, {27'd0, o.rs1});
                chk("rt_imm_i", imm, o.imm);
            end
            7'h23, 7'h63: begin
                if (o.op == 7'h23) imm = {{20{w[31]}}, w[31:25], w[11:7]};
                else imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                chk("rt_f3",  {29'd0, w[14:12]}, {29'd0, o.f3});
                chk("rt_rs1", {27'd0, w[19:15]}, {27'd0, o.rs1});
                chk("rt_rs2", {27'd0, w[24:20]}, {27'd0, o.rs2});
                chk("rt_imm_sb", imm, o.imm);
            end
            7'h37, 7'h17: begin
                chk("rt_rd", {27'd0, w[11:7]}, {27'd0, o.rd});
                chk("rt_imm_u", {w[31:12], 12'h0}, o.imm);
            end
            default: begin
                imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                chk("rt_rd", {27'd0, w[11:7]}, {27'd0, o.rd});
                chk("rt_imm_j", imm, o.imm);
            end
        endcase
    endtask

    // Every-cycle comparison of DUT outputs with the model, on the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
            chk("o_ready", 32'(o_ready), 32'(exp_q.size() < 2));
            chk("o_err_count", {24'd0, o_err_count}, 32'(m_err));
            if (exp_q.size() != 0) begin
                chk("o_instruction", o_instruction, exp_q[0][31:0]);
                chk("o_error", 32'(o_error), 32'(exp_q[0][32]));
                if (rt_mode) rt_check(org_q[0], o_instruction);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                                   7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input fields_t f, input bit v);
        i_opcode = f.op;  i_funct7 = f.f7;  i_funct3 = f.f3;
        i_rs1 = f.rs1;    i_rs2 = f.rs2;    i_rd = f.rd;
        i_imm = f.imm;    i_valid = v;
    endtask

    function automatic fields_t mk(input logic [6:0] op, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [31:0] imm);
        fields_t f;
        f = '{op, 8'h00, 3'h0, rs1, rs2, rd, imm};
        return f;
    endfunction

    function automatic fields_t gen_legal();
        fields_t f;
        int v;
        f.op  = legal_ops[$urandom_range(0, 9)];
        f.f7  = 8'($urandom);
        f.f3  = 3'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.rd  = 5'($urandom);
        case (f.op)
            7'h33:        f.imm = $urandom;
            7'h23, 7'h13, 7'h03, 7'h67, 7'h73: begin
                v = int'($urandom_range(0, 4095)) - 2048;  f.imm = v;
            end
            7'h63: begin
                v = (int'($urandom_range(0, 4095)) - 2048) * 2;  f.imm = v;
            end
            7'h37, 7'h17: f.imm = $urandom & 32'hFFFF_F000;
            default: begin
                v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;  f.imm = v;
            end
        endcase
        return f;
    endfunction

    fields_t v_addi, v_add, v_beq, v_jal, v_lui, v_bad, v_beq7, f;
    logic [32:0] pin;
    int guard;

    initial begin
        v_addi = mk(7'h13, 5'd0, 5'd0, 5'd1, 32'd5);
        v_add  = mk(7'h33, 5'd1, 5'd2, 5'd3, 32'd0);
        v_beq  = mk(7'h63, 5'd1, 5'd2, 5'd0, 32'd8);
        v_jal  = mk(7'h6F, 5'd0, 5'd0, 5'd1, 32'h800);
        v_lui  = mk(7'h37, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
        v_bad  = mk(7'h7F, 5'd1, 5'd2, 5'd3, 32'd0);
        v_beq7 = mk(7'h63, 5'd1, 5'd2, 5'd0, 32'd7);

        // Pin the model against hand-assembled words.
        pin = ref_encode(v_addi); chk("model_addi", pin[31:0], 32'h0050_0093);
        pin = ref_encode(v_beq);  chk("model_beq",  pin[31:0], 32'h0020_8463);
        pin = ref_encode(v_jal);  chk("model_jal",  pin[31:0], 32'h0010_00EF);
        pin = ref_encode(v_beq7); chk("model_beq7_err", {31'd0, pin[32]}, 32'd1);

        // Reset state.
        rst = 1; tick(); tick(); rst = 0;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_instr", o_instruction, 0);
        chk("rst_error", 32'(o_error), 0);
        chk("rst_errcnt", {24'd0, o_err_count}, 0);

        // Basic encodes, i_ready high: each result visible one cycle later.
        i_ready = 1;
        put(v_addi, 1); tick(); chk("addi_valid", 32'(o_valid), 1); chk("addi", o_instruction, 32'h0050_0093);
        put(v_add, 1);  tick(); chk("add", o_instruction, 32'h0020_81B3);
        put(v_beq, 1);  tick(); chk("beq", o_instruction, 32'h0020_8463);
        put(v_jal, 1);  tick(); chk("jal", o_instruction, 32'h0010_00EF);
        put(v_lui, 1);  tick(); chk("lui", o_instruction, 32'h1234_52B7);

        // Error beats keep their slot and bump the counter.
        put(v_bad, 1);  tick();
        chk("bad_instr", o_instruction, 0); chk("bad_err", 32'(o_error), 1);
        chk("bad_cnt", {24'd0, o_err_count}, 1);
        put(v_beq7, 1); tick();
        chk("beq7_err", 32'(o_error), 1); chk("beq7_cnt", {24'd0, o_err_count}, 2);
        put(v_addi, 1); tick();
        chk("after_err_instr", o_instruction, 32'h0050_0093); chk("after_err_err", 32'(o_error), 0);
        put(v_addi, 0); tick(); tick();

        // Backpressure: two beats fill the buffer, the third stalls.
        i_ready = 0;
        put(v_add, 1); tick(); chk("bp_ready1", 32'(o_ready), 1);
        put(v_beq, 1); tick(); chk("bp_ready2", 32'(o_ready), 0);
        put(v_jal, 1); tick(); chk("bp_ready3", 32'(o_ready), 0); chk("bp_head_hold", o_instruction, 32'h0020_81B3);
        i_ready = 1;   tick(); chk("bp_out2", o_instruction, 32'h0020_8463);
        tick();        chk("bp_out3", o_instruction, 32'h0010_00EF);
        put(v_jal, 0); tick(); chk("bp_drained", 32'(o_valid), 0);

        // Stall with two beats buffered, then reset mid-stream.
        i_ready = 0;
        put(v_addi, 1); tick(); put(v_lui, 1); tick();
        clk_en = 0; i_ready = 1; put(v_jal, 1);
        repeat (4) begin
            tick();
            chk("stall_instr", o_instruction, 32'h0050_0093);
            chk("stall_valid", 32'(o_valid), 1);
        end
        clk_en = 1; rst = 1; tick(); rst = 0;
        chk("rst_mid_valid", 32'(o_valid), 0);
        chk("rst_mid_cnt", {24'd0, o_err_count}, 0);
        chk("rst_mid_ready", 32'(o_ready), 1);
        put(v_lui, 1); tick(); chk("post_rst_beat", o_instruction, 32'h1234_52B7);
        put(v_lui, 0); tick(); chk("post_rst_alone", 32'(o_valid), 0);

        // Random mixed traffic, including illegal encodings and stalls.
        repeat (600) begin
            if ($urandom_range(0, 4) == 0) begin
                f = '{7'($urandom), 8'($urandom), 3'($urandom), 5'($urandom),
                      5'($urandom), 5'($urandom), $urandom};
            end else begin
                f = gen_legal();
                if ($urandom_range(0, 3) == 0) f.imm = $urandom;
            end
            put(f, 1'($urandom_range(0, 9) < 7));
            clk_en  = ($urandom_range(0, 9) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Round trip: 1000 legal instructions, held until accepted.
        clk_en = 1; put(v_addi, 0); rst = 1; tick(); rst = 0;
        rt_mode = 1;
        f = gen_legal();
        guard = 0;
        while (rt_in < 1000 && guard < 20000) begin
            put(f, 1);
            i_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_push) f = gen_legal();
            guard++;
        end
        put(f, 0); i_ready = 1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("rt_accepted", 32'(rt_in), 32'd1000);
        chk("rt_delivered", 32'(rt_out), 32'd1000);
        chk("rt_errcnt", {24'd0, o_err_count}, 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
